// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI SRAM arbiter: opcodes, frame layout, FSM states, port IDs.
// Pure declarations; no latency or backpressure of its own.
package spi_ram_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         SPI_ADDR_W    = 16;
    localparam int         SPI_WORD_W    = 16;
    localparam int         FRAME_W       = 8 + SPI_ADDR_W + SPI_WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        GAP
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Read frames carry zeros in the data slot so mosi idles low while miso is shifted in.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic                  we,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_WORD_W-1:0] wdata
    );
        return {(we ? SPI_CMD_WRITE : SPI_CMD_READ), addr, (we ? wdata : {SPI_WORD_W{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Serialises one 40-bit SPI mode-0 frame at clk/2 and shifts in the trailing 16 miso bits.
// Latency: 80 clk from start_i to done_o; start_i is only honoured by the owner when idle.
module spi_word_shifter
    import spi_ram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               spi_miso_i,
    output logic               done_o,
    output logic               bit_end_o,
    output logic [5:0]         bit_cnt_o,
    output logic [15:0]        rx_o,
    output logic               spi_sck_o,
    output logic               spi_mosi_o
);

    logic               active_q;
    logic               sck_q;
    logic               mosi_q;
    logic [5:0]         cnt_q;
    logic [FRAME_W-2:0] tx_q;
    logic [14:0]        rx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= frame_i[FRAME_W-1];
            tx_q     <= frame_i[FRAME_W-2:0];
            cnt_q    <= '0;
        end else if (active_q) begin
            if (!sck_q) begin
                sck_q <= 1'b1;
            end else begin
                // Falling sck edge: miso is sampled here and the next bit is presented.
                sck_q <= 1'b0;
                rx_q  <= {rx_q[13:0], spi_miso_i};
                if (cnt_q == 6'(FRAME_W - 1)) begin
                    active_q <= 1'b0;
                    mosi_q   <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q + 6'd1;
                    mosi_q <= tx_q[FRAME_W-2];
                    tx_q   <= {tx_q[FRAME_W-3:0], 1'b0};
                end
            end
        end
    end

    assign bit_end_o  = active_q && sck_q;
    assign done_o     = bit_end_o && (cnt_q == 6'(FRAME_W - 1));
    assign bit_cnt_o  = cnt_q;
    assign rx_o       = {rx_q, spi_miso_i};
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI SRAM between a read-only fetch port and a load/store data port, alternating on contention.
// Latency: valid pulses 80 clk after the grant edge; requesters wait (req held) while another access runs.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CS_GAP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_e             state_q;
    logic               port_q;
    logic               we_q;
    logic               last_grant_q;
    logic [GAP_W-1:0]   gap_q;
    logic               cs_q;
    logic               busy_q;
    logic               if_valid_q;
    logic               d_valid_q;
    logic [DATA_W-1:0]  if_data_q;
    logic [DATA_W-1:0]  d_rdata_q;

    logic               grant_vld;
    logic               grant_port;
    logic               grant_we;
    logic [ADDR_W-1:0]  grant_addr;
    logic [FRAME_W-1:0] grant_frame;

    logic               sh_done;
    logic               sh_bit_end;
    logic [5:0]         sh_bit_cnt;
    logic [15:0]        sh_rx;

    // Contention goes to whichever port did not win last time.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = PORT_IF;
        if (state_q == IDLE) begin
            if (if_req && d_req) begin
                grant_vld  = 1'b1;
                grant_port = (last_grant_q == PORT_IF) ? PORT_D : PORT_IF;
            end else if (d_req) begin
                grant_vld  = 1'b1;
                grant_port = PORT_D;
            end else if (if_req) begin
                grant_vld  = 1'b1;
                grant_port = PORT_IF;
            end
        end
    end

    assign grant_we    = (grant_port == PORT_D) && d_we;
    assign grant_addr  = (grant_port == PORT_D) ? d_addr : if_addr;
    assign grant_frame = build_frame(grant_we, SPI_ADDR_W'(grant_addr), d_wdata);

    spi_word_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (grant_vld),
        .frame_i    (grant_frame),
        .spi_miso_i (spi_miso),
        .done_o     (sh_done),
        .bit_end_o  (sh_bit_end),
        .bit_cnt_o  (sh_bit_cnt),
        .rx_o       (sh_rx),
        .spi_sck_o  (spi_sck),
        .spi_mosi_o (spi_mosi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            port_q       <= PORT_IF;
            we_q         <= 1'b0;
            last_grant_q <= PORT_IF;
            gap_q        <= '0;
            cs_q         <= 1'b1;
            busy_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            d_valid_q    <= 1'b0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        port_q       <= grant_port;
                        we_q         <= grant_we;
                        last_grant_q <= grant_port;
                        cs_q         <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= CMD;
                    end
                end
                CMD: begin
                    if (sh_bit_end && sh_bit_cnt == 6'd7) begin
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (sh_bit_end && sh_bit_cnt == 6'd23) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sh_done) begin
                        cs_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        gap_q   <= '0;
                        state_q <= GAP;
                        if (port_q == PORT_D) begin
                            d_valid_q <= 1'b1;
                            if (!we_q) begin
                                d_rdata_q <= sh_rx;
                            end
                        end else begin
                            if_valid_q <= 1'b1;
                            if_data_q  <= sh_rx;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_W'(CS_GAP - 1)) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_cs   = cs_q;
    assign busy     = busy_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign if_data  = if_data_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Randomised bench for spi_ram_arbiter: an SPI SRAM slave model plus a reference arbiter/memory model.
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int CS_GAP = 2;
    localparam int LAT    = 80;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              busy;
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    spi_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .busy(busy),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_word(input int i);
        if (i == 5)  return 16'hABCD;
        if (i == 16) return 16'h8001;
        return 16'((i * 40503) ^ 23130);
    endfunction

    // ---------------- SPI SRAM slave (device side) ----------------
    logic [15:0] sram [1024];
    logic [39:0] frm_q [$];
    logic [39:0] sl_sh;
    int          sl_nb;
    logic [7:0]  sl_cmd;
    logic [15:0] sl_addr;
    logic        cs_prev = 1'b1;

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 1024; i++) sram[i] = init_word(i);
        sl_sh = '0; sl_nb = 0; sl_cmd = '0; sl_addr = '0;
        forever begin
            @(posedge spi_sck or spi_cs);
            if (spi_cs !== cs_prev) begin
                if (spi_cs === 1'b0) begin
                    sl_nb = 0;
                    sl_sh = '0;
                end else begin
                    spi_miso = 1'b0;
                    if (sl_nb == 40) begin
                        frm_q.push_back(sl_sh);
                        if (sl_sh[39:32] == 8'h02) sram[sl_sh[25:16]] = sl_sh[15:0];
                    end
                end
                cs_prev = spi_cs;
            end else if (spi_sck === 1'b1 && spi_cs === 1'b0) begin
                sl_sh = {sl_sh[38:0], spi_mosi};
                if (sl_nb == 23) begin
                    sl_cmd  = sl_sh[23:16];
                    sl_addr = sl_sh[15:0];
                end
                if (sl_nb >= 24 && sl_nb < 40 && sl_cmd == 8'h03) begin
                    w = sram[sl_addr[9:0]];
                    spi_miso = w[39 - sl_nb];
                end
                sl_nb++;
            end
        end
    end

    // ---------------- Reference model ----------------
    logic [15:0] ref_mem [1024];
    txn_t        exp_q [$];
    logic        exp_last;
    logic [15:0] m_if_data;
    logic [15:0] m_d_rdata;
    int          vcyc [$];

    task automatic plan(input bit want_if, input bit want_d);
        txn_t ti, td;
        ti = '{port: PORT_IF, we: 1'b0, addr: if_addr, wdata: 16'h0};
        td = '{port: PORT_D, we: d_we, addr: d_addr, wdata: d_wdata};
        if (want_if && want_d) begin
            if (exp_last == PORT_IF) begin
                exp_q.push_back(td); exp_q.push_back(ti); exp_last = PORT_IF;
            end else begin
                exp_q.push_back(ti); exp_q.push_back(td); exp_last = PORT_D;
            end
        end else if (want_d) begin
            exp_q.push_back(td); exp_last = PORT_D;
        end else if (want_if) begin
            exp_q.push_back(ti); exp_last = PORT_IF;
        end
        if_req = want_if;
        d_req  = want_d;
    endtask

    task automatic complete(input logic dport);
        txn_t        t;
        logic [39:0] ef;
        if (exp_q.size() == 0) begin
            chk_eq("unexpected_valid", 1, 0);
            return;
        end
        t = exp_q.pop_front();
        chk_eq("valid_port", dport, t.port);
        chk_eq("both_valid", if_valid & d_valid, 0);
        ef = {(t.we ? 8'h02 : 8'h03), 6'b0, t.addr, (t.we ? t.wdata : 16'h0)};
        if (frm_q.size() == 0) chk_eq("frame_missing", 0, 1);
        else chk_eq("mosi_frame", frm_q.pop_front(), ef);
        if (t.we) ref_mem[t.addr] = t.wdata;
        else if (t.port == PORT_D) m_d_rdata = ref_mem[t.addr];
        else m_if_data = ref_mem[t.addr];
        chk_eq("if_data", if_data, m_if_data);
        chk_eq("d_rdata", d_rdata, m_d_rdata);
    endtask

    task automatic scramble(input logic port);
        if (port == PORT_D) begin
            d_addr  = ADDR_W'($urandom);
            d_we    = 1'($urandom);
            d_wdata = DATA_W'($urandom);
        end else begin
            if_addr = ADDR_W'($urandom);
        end
    endtask

    task automatic run_until(input int nvalid, input bit auto_drop);
        int   got, g, hi, budget;
        bit   seen_rise;
        logic pcs, pv;
        got = 0; g = -1; hi = 0; budget = 0; seen_rise = 0;
        pcs = spi_cs; pv = 1'b0;
        vcyc.delete();
        while (got < nvalid && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (pcs && !spi_cs) begin
                g = cyc;
                if (seen_rise) chk_eq("cs_gap", hi >= CS_GAP, 1);
                if (auto_drop && exp_q.size() > 0) scramble(exp_q[0].port);
            end
            if (!pcs && spi_cs) begin
                seen_rise = 1;
                hi = 0;
            end
            if (spi_cs) hi++;
            if (!spi_cs && g >= 0 && cyc == g + 40) chk_eq("busy_mid", busy, 1);
            if ((if_valid || d_valid) && pv) chk_eq("valid_width", 2, 1);
            if (if_valid || d_valid) begin
                got++;
                vcyc.push_back(cyc);
                chk_eq("latency", cyc - g, LAT);
                complete(d_valid);
                if (auto_drop) begin
                    if (d_valid) d_req = 1'b0;
                    else if_req = 1'b0;
                end
            end
            pcs = spi_cs;
            pv  = if_valid | d_valid;
        end
        if (got < nvalid) chk_eq("timeout_valid", got, nvalid);
    endtask

    task automatic idle(input int n, input string tag);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (if_valid || d_valid || !spi_cs || spi_sck || busy) bad++;
        end
        chk_eq(tag, bad, 0);
    endtask

    task automatic check_separation(input string tag);
        for (int i = 1; i < vcyc.size(); i++) chk_eq(tag, vcyc[i] - vcyc[i-1], LAT + CS_GAP + 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, g, pat;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        exp_last = PORT_IF; m_if_data = '0; m_d_rdata = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_cs", spi_cs, 1);
        chk_eq("rst_sck", spi_sck, 0);
        chk_eq("rst_mosi", spi_mosi, 0);
        chk_eq("rst_if_valid", if_valid, 0);
        chk_eq("rst_d_valid", d_valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_if_data", if_data, 0);
        chk_eq("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        idle(3, "post_rst_idle");

        // Contention straight out of reset: data wins first.
        if_addr = 10'h123; d_addr = 10'h0AA; d_we = 1'b0;
        plan(1, 1);
        run_until(2, 1);
        if (vcyc.size() == 2) chk_eq("contend_sep", vcyc[1] - vcyc[0], LAT + CS_GAP + 1);
        idle(6, "contend_quiet");

        // Single fetch from 0x005.
        if_addr = 10'h005;
        plan(1, 0);
        run_until(1, 1);
        chk_eq("fetch_abcd", if_data, 16'hABCD);
        idle(CS_GAP + 4, "fetch_cs_high");

        // Data write to the top word.
        d_addr = 10'h3FF; d_we = 1'b1; d_wdata = 16'h1234;
        plan(0, 1);
        run_until(1, 1);
        idle(5, "write_quiet");

        // Data read, then a fetch must leave d_rdata alone.
        d_addr = 10'h010; d_we = 1'b0;
        plan(0, 1);
        run_until(1, 1);
        chk_eq("d_rdata_8001", d_rdata, 16'h8001);
        if_addr = 10'h3FF;
        plan(1, 0);
        run_until(1, 1);
        chk_eq("d_rdata_hold", d_rdata, 16'h8001);
        chk_eq("fetch_after_write", if_data, 16'h1234);
        idle(5, "hold_quiet");

        // Fairness: both held for six back-to-back transactions.
        if_addr = ADDR_W'($urandom); d_addr = ADDR_W'($urandom);
        d_we = 1'($urandom); d_wdata = DATA_W'($urandom);
        for (int k = 0; k < 3; k++) begin
            txn_t td, ti;
            td = '{port: PORT_D, we: d_we, addr: d_addr, wdata: d_wdata};
            ti = '{port: PORT_IF, we: 1'b0, addr: if_addr, wdata: 16'h0};
            if (exp_last == PORT_IF) begin exp_q.push_back(td); exp_q.push_back(ti); end
            else begin exp_q.push_back(ti); exp_q.push_back(td); end
        end
        if_req = 1'b1; d_req = 1'b1;
        run_until(6, 0);
        if_req = 1'b0; d_req = 1'b0;
        check_separation("fair_sep");
        idle(6, "fair_quiet");

        // Reset during bit 10 of the address phase.
        if_addr = ADDR_W'($urandom);
        if_req = 1'b1;
        w = 0;
        while (spi_cs && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk_eq("rst_mid_grant", spi_cs, 0);
        g = cyc;
        w = 0;
        while (cyc < g + 37 && w < 100) begin
            @(negedge clk);
            w++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_eq("rst_mid_cs", spi_cs, 1);
        chk_eq("rst_mid_sck", spi_sck, 0);
        chk_eq("rst_mid_busy", busy, 0);
        rst = 1'b0; if_req = 1'b0;
        exp_last = PORT_IF; m_if_data = '0; m_d_rdata = '0;
        idle(100, "rst_mid_no_valid");
        chk_eq("rst_mid_no_frame", frm_q.size(), 0);
        chk_eq("rst_mid_if_data", if_data, 0);

        // Clean frame after the abort.
        if_addr = ADDR_W'($urandom);
        plan(1, 0);
        run_until(1, 1);
        idle(4, "clean_quiet");

        // Randomised mix of single and contended requests.
        for (int it = 0; it < 24; it++) begin
            if_addr = ADDR_W'($urandom); d_addr = ADDR_W'($urandom);
            d_we = 1'($urandom); d_wdata = DATA_W'($urandom);
            pat = $urandom_range(0, 2);
            plan(pat != 1, pat != 0);
            run_until((pat == 2) ? 2 : 1, 1);
            if (pat == 2 && vcyc.size() == 2) chk_eq("rand_sep", vcyc[1] - vcyc[0], LAT + CS_GAP + 1);
            repeat ($urandom_range(CS_GAP + 1, CS_GAP + 4)) @(negedge clk);
        end
        idle(10, "final_quiet");
        chk_eq("exp_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
